// File: rtl/serial_signmag32_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign-magnitude decoder.
package serial_signmag32_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_neg_cell.sv
// One-bit serial negate cell: passes bits through up to and including the first 1,
// then inverts every later bit when invert_en is set.
module serial_neg_cell (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic invert_en,
  input  logic bit_in,
  output logic bit_out
);

  logic r_seen_one;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seen_one <= 1'b0;
    end else if (clear) begin
      r_seen_one <= 1'b0;
    end else if (enable) begin
      r_seen_one <= r_seen_one | bit_in;
    end
  end

  assign bit_out = (invert_en & r_seen_one) ? ~bit_in : bit_in;

endmodule

// File: rtl/serial_signmag32.sv
// Bit-serial two's-complement to sign-magnitude decoder, one bit per clock, LSB first.
module serial_signmag32
  import serial_signmag32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operandA,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude,
  output logic             is_zero
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic             r_zero;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_bit;
  logic [WIDTH-1:0] w_mag_next;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_last     = w_shift && (r_count == CNT_W'(WIDTH - 1));
  assign w_mag_next = {w_bit, r_mag[WIDTH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start is only honoured outside SHIFT, so a running conversion is never disturbed.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SHIFT;
          w_accept     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_accept     = start;
        w_state_next = start ? ST_SHIFT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_shreg <= '0;
      r_mag   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_shreg <= operandA;
      r_sign  <= operandA[WIDTH-1];
      r_zero  <= 1'b0;
    end else if (w_shift) begin
      r_count <= r_count + CNT_W'(1);
      r_shreg <= r_shreg >> 1;
      r_mag   <= w_mag_next;
      if (w_last) begin
        r_zero <= (w_mag_next == '0);
      end
    end
  end

  serial_neg_cell u_neg_cell (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_accept),
    .enable   (w_shift),
    .invert_en(r_sign),
    .bit_in   (r_shreg[0]),
    .bit_out  (w_bit)
  );

  assign busy      = w_shift;
  assign done      = (r_state == ST_DONE);
  assign sign      = r_sign;
  assign magnitude = r_mag;
  assign is_zero   = r_zero;

endmodule

// File: tb/tb_serial_signmag32.sv
// Directed and random checks of serial_signmag32 against hand-computed sign/magnitude values.
module tb_serial_signmag32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operandA;
  logic        busy;
  logic        done;
  logic        sign;
  logic [31:0] magnitude;
  logic        is_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int cnt;

  serial_signmag32 dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .operandA (operandA),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .magnitude(magnitude),
    .is_zero  (is_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] op);
    @(negedge clock);
    start    = 1'b1;
    operandA = op;
  endtask

  // Counts edges until done is seen; optionally pulses start with inj_op at edge count inj_at.
  task automatic wait_done(output int n, input int inj_at, input logic [31:0] inj_op);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      #1;
      start = (n == inj_at);
      if (n == inj_at) operandA = inj_op;
    end while (!done && n < 100);
    if (!done) check("timeout", 32'(n), 32'd33);
  endtask

  task automatic count_done(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (done) c++;
    end
  endtask

  task automatic convert_check(input string tag, input logic [31:0] op, input logic exp_sign,
                               input logic [31:0] exp_mag, input logic exp_zero);
    int n;
    launch(op);
    wait_done(n, -1, 32'h0);
    check({tag, "_lat"}, 32'(n), 32'd33);
    check({tag, "_sign"}, {31'b0, sign}, {31'b0, exp_sign});
    check({tag, "_mag"}, magnitude, exp_mag);
    check({tag, "_zero"}, {31'b0, is_zero}, {31'b0, exp_zero});
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    operandA = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sign", {31'b0, sign}, 32'd0);
    check("rst_mag", magnitude, 32'd0);
    check("rst_zero", {31'b0, is_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Positive operand; done must be a single-cycle pulse.
    convert_check("pos5", 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0);
    @(posedge clock);
    #1;
    check("pos5_pulse", {31'b0, done}, 32'd0);
    check("pos5_hold", magnitude, 32'h0000_0005);

    convert_check("neg5", 32'hFFFF_FFFB, 1'b1, 32'h0000_0005, 1'b0);
    convert_check("minint", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0);
    convert_check("zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1);
    convert_check("neg1", 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);
    convert_check("mixed", 32'hFFFF_0000, 1'b1, 32'h0001_0000, 1'b0);

    // A start during SHIFT must be ignored.
    launch(32'h0000_1234);
    wait_done(lat, 10, 32'hFFFF_FFFF);
    check("busy_ign_lat", 32'(lat), 32'd33);
    check("busy_ign_mag", magnitude, 32'h0000_1234);
    check("busy_ign_sign", {31'b0, sign}, 32'd0);
    count_done(40, cnt);
    check("busy_ign_pulses", 32'(cnt), 32'd0);

    // Back-to-back: start held across the DONE cycle.
    launch(32'h0000_0007);
    wait_done(lat, -1, 32'h0);
    check("b2b_first_mag", magnitude, 32'h0000_0007);
    start    = 1'b1;
    operandA = 32'hFFFF_FFFF;
    wait_done(lat, -1, 32'h0);
    check("b2b_lat", 32'(lat), 32'd33);
    check("b2b_mag", magnitude, 32'h0000_0001);
    check("b2b_sign", {31'b0, sign}, 32'd1);

    // Reset mid-conversion aborts without a done pulse.
    launch(32'h1234_5678);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_sign", {31'b0, sign}, 32'd0);
    check("abort_mag", magnitude, 32'd0);
    check("abort_zero", {31'b0, is_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_done(40, cnt);
    check("abort_pulses", 32'(cnt), 32'd0);
    convert_check("after_abort", 32'hEDCB_A988, 1'b1, 32'h1234_5678, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      logic [31:0] op;
      logic [31:0] exp_mag;
      op      = $urandom;
      if (k % 8 == 0) op[31] = 1'b1;
      exp_mag = op[31] ? (~op + 32'd1) : op;
      launch(op);
      wait_done(lat, -1, 32'h0);
      check("rnd_sign", {31'b0, sign}, {31'b0, op[31]});
      check("rnd_mag", magnitude, exp_mag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
